// File: rtl/gc_refresh_scheduler.sv
// Rotating copy-refresh sequencer for a ring of three GC-DRAM banks: retention timer,
// copy handshake toward the wrappers, active-bank pointer and user strobe steering.
module gc_refresh_scheduler #(
   parameter int NUM_BANKS  = 3,
   parameter int REF_PERIOD = 1024,
   parameter int SR_CYCLES  = 129,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 ref_force,
   input  logic                 u_we,
   input  logic                 u_re,
   input  logic [NUM_BANKS-1:0] ref_done_i,
   output logic [NUM_BANKS-1:0] u_we_bank,
   output logic [NUM_BANKS-1:0] u_re_bank,
   output logic [NUM_BANKS-1:0] ref_en_bank,
   output logic [NUM_BANKS-1:0] start_sr_bank,
   output logic [1:0]           active_bank,
   output logic [1:0]           rd_sel,
   output logic                 ref_busy,
   output logic                 ref_err,
   output logic [CNT_W-1:0]     ref_cnt
);

   localparam int TW = $clog2(REF_PERIOD + 1);
   localparam int CW = $clog2(SR_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_COPY, S_SWITCH} state_t;

   function automatic logic [1:0] next_bank(input logic [1:0] b);
      return (b == 2'd2) ? 2'd0 : b + 2'd1;
   endfunction

   function automatic logic [NUM_BANKS-1:0] onehot(input logic [1:0] b);
      return {{(NUM_BANKS-1){1'b0}}, 1'b1} << b;
   endfunction

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [CW-1:0]        copy_q, copy_d;
   logic [1:0]           active_q, active_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic [NUM_BANKS-1:0] ref_en_q, ref_en_d;
   logic [NUM_BANKS-1:0] sr_q, sr_d;
   logic                 busy_q, busy_d;
   logic [1:0]           rd_sel_q, rd_sel_d;

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      copy_d   = copy_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            // timer only advances while waiting, so a blocked refresh keeps its place
            if (en) begin
               if (timer_q == TW'(REF_PERIOD - 1) || ref_force) state_d = S_START;
               else timer_d = timer_q + 1'b1;
            end
         end
         S_START: begin
            state_d = S_COPY;
            copy_d  = '0;
         end
         S_COPY: begin
            if (copy_q == CW'(SR_CYCLES - 1)) state_d = S_SWITCH;
            else copy_d = copy_q + 1'b1;
         end
         S_SWITCH: begin
            state_d  = S_IDLE;
            active_d = next_bank(active_q);
            timer_d  = '0;
            cnt_d    = cnt_q + 1'b1;
            if (!ref_done_i[active_q]) err_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // outputs decoded from next state so they are flop-driven in the cycle they apply
      busy_d   = (state_d == S_START) || (state_d == S_COPY);
      ref_en_d = busy_d ? onehot(active_d) : '0;
      sr_d     = (state_d == S_START) ? onehot(active_d) : '0;
      rd_sel_d = busy_d ? next_bank(active_d) : active_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         copy_q   <= '0;
         active_q <= 2'd0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         ref_en_q <= '0;
         sr_q     <= '0;
         busy_q   <= 1'b0;
         rd_sel_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         copy_q   <= copy_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         ref_en_q <= ref_en_d;
         sr_q     <= sr_d;
         busy_q   <= busy_d;
         rd_sel_q <= rd_sel_d;
      end
   end

   assign u_we_bank     = u_we ? onehot(active_q) : '0;
   assign u_re_bank     = u_re ? onehot(active_q) : '0;
   assign ref_en_bank   = ref_en_q;
   assign start_sr_bank = sr_q;
   assign active_bank   = active_q;
   assign rd_sel        = rd_sel_q;
   assign ref_busy      = busy_q;
   assign ref_err       = err_q;
   assign ref_cnt       = cnt_q;

endmodule

// File: tb/tb_gc_refresh_scheduler.sv
// Directed bench for gc_refresh_scheduler with a 300-cycle retention period.
module tb_gc_refresh_scheduler;
   localparam int P = 300;

   logic        clk = 1'b0;
   logic        rst, en, ref_force, u_we, u_re;
   logic [2:0]  ref_done_i;
   logic [2:0]  u_we_bank, u_re_bank, ref_en_bank, start_sr_bank;
   logic [1:0]  active_bank, rd_sel;
   logic        ref_busy, ref_err;
   logic [15:0] ref_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gc_refresh_scheduler #(.NUM_BANKS(3), .REF_PERIOD(P), .SR_CYCLES(129), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .ref_force(ref_force), .u_we(u_we), .u_re(u_re),
      .ref_done_i(ref_done_i), .u_we_bank(u_we_bank), .u_re_bank(u_re_bank),
      .ref_en_bank(ref_en_bank), .start_sr_bank(start_sr_bank), .active_bank(active_bank),
      .rd_sel(rd_sel), .ref_busy(ref_busy), .ref_err(ref_err), .ref_cnt(ref_cnt)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // negedges until a start pulse is visible; -1 if the budget runs out
   task automatic wait_start(input int budget, output int n);
      n = 0;
      while (start_sr_bank == 3'b000 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (start_sr_bank == 3'b000) n = -1;
   endtask

   // from a refresh cycle, measure ref_en/start_sr widths; returns at the first IDLE negedge
   task automatic run_copy(output int sr_n, output int en_n, output logic [2:0] src);
      src  = ref_en_bank;
      sr_n = 0;
      en_n = 0;
      while (ref_en_bank != 3'b000 && en_n < 300) begin
         if (start_sr_bank != 3'b000) sr_n++;
         en_n++;
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [36:0] all_out;
      rst = 1'b1; en = 1'b0; ref_force = 1'b0; u_we = 1'b0; u_re = 1'b0; ref_done_i = 3'b111;
      tick(3);
      all_out = {u_we_bank, u_re_bank, ref_en_bank, start_sr_bank, active_bank, rd_sel,
                 ref_busy, ref_err, ref_cnt};
      checks++;
      if (all_out !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs got %0h expected 0", all_out);
      end
   endtask

   task automatic test_timer_expiry();
      int n, sr_n, en_n;
      logic [2:0] src;
      rst = 1'b0;
      en  = 1'b1;
      wait_start(400, n);
      checks++;
      if (n !== P) begin errors++; $display("FAIL expiry_latency got %0d expected %0d", n, P); end
      checks++;
      if (rd_sel !== 2'd1 || ref_busy !== 1'b1) begin
         errors++; $display("FAIL start_rdsel_busy got %0d/%0b expected 1/1", rd_sel, ref_busy);
      end
      run_copy(sr_n, en_n, src);
      checks++;
      if (src !== 3'b001 || sr_n !== 1 || en_n !== 130) begin
         errors++;
         $display("FAIL expiry_pulses got src=%b sr=%0d en=%0d expected 001/1/130", src, sr_n, en_n);
      end
      checks++;
      if (active_bank !== 2'd1 || ref_cnt !== 16'd1 || ref_busy !== 1'b0 || rd_sel !== 2'd1) begin
         errors++;
         $display("FAIL after_first got act=%0d cnt=%0d busy=%b rd=%0d expected 1/1/0/1",
                  active_bank, ref_cnt, ref_busy, rd_sel);
      end
      u_we = 1'b1;
      #1;
      checks++;
      if (u_we_bank !== 3'b010) begin errors++; $display("FAIL we_steer got %b expected 010", u_we_bank); end
      u_we = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n, sr_n, en_n;
      logic [2:0] src;
      time t_prev;
      logic [2:0] exp_src[3] = '{3'b001, 3'b010, 3'b100};
      logic [1:0] exp_act[3] = '{2'd1, 2'd2, 2'd0};
      do_reset();
      ref_force = 1'b1;
      t_prev = 0;
      for (int i = 0; i < 3; i++) begin
         wait_start(500, n);
         if (i == 2) ref_force = 1'b0;
         if (i > 0) begin
            checks++;
            if (($time - t_prev) / 10 !== 132) begin
               errors++;
               $display("FAIL b2b_spacing%0d got %0d expected 132", i, ($time - t_prev) / 10);
            end
         end
         t_prev = $time;
         run_copy(sr_n, en_n, src);
         checks++;
         if (src !== exp_src[i] || active_bank !== exp_act[i]) begin
            errors++;
            $display("FAIL b2b_rot%0d got src=%b act=%0d expected %b/%0d",
                     i, src, active_bank, exp_src[i], exp_act[i]);
         end
      end
      checks++;
      if (ref_cnt !== 16'd3 || ref_err !== 1'b0) begin
         errors++; $display("FAIL b2b_cnt got cnt=%0d err=%b expected 3/0", ref_cnt, ref_err);
      end
   endtask

   task automatic test_write_during_copy();
      int n, sr_n, en_n;
      logic [2:0] src;
      ref_force = 1'b1;
      wait_start(5, n);
      ref_force = 1'b0;
      tick(50);
      u_we = 1'b1;
      u_re = 1'b1;
      ref_force = 1'b1;
      #1;
      checks++;
      if (u_we_bank !== 3'b001 || u_re_bank !== 3'b001 || ref_en_bank !== 3'b001 || rd_sel !== 2'd1) begin
         errors++;
         $display("FAIL copy_steer got we=%b re=%b ren=%b rd=%0d expected 001/001/001/1",
                  u_we_bank, u_re_bank, ref_en_bank, rd_sel);
      end
      tick(1);
      u_we = 1'b0; u_re = 1'b0; ref_force = 1'b0;
      run_copy(sr_n, en_n, src);
      u_re = 1'b1;
      #1;
      checks++;
      if (active_bank !== 2'd1 || u_re_bank !== 3'b010) begin
         errors++; $display("FAIL post_copy_read got act=%0d re=%b expected 1/010", active_bank, u_re_bank);
      end
      u_re = 1'b0;
      wait_start(20, n);
      checks++;
      if (n !== -1) begin errors++; $display("FAIL force_not_queued got %0d expected -1", n); end
   endtask

   task automatic test_en_hold();
      int n, bad, sr_n, en_n;
      logic [2:0] src;
      tick(180);
      en = 1'b0;
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (start_sr_bank != 3'b000 || ref_busy) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL en_low_refresh got %0d expected 0", bad); end
      en = 1'b1;
      wait_start(200, n);
      checks++;
      if (n !== 100) begin errors++; $display("FAIL en_resume_latency got %0d expected 100", n); end
      run_copy(sr_n, en_n, src);
      checks++;
      if (src !== 3'b010 || active_bank !== 2'd2) begin
         errors++; $display("FAIL en_resume_rot got src=%b act=%0d expected 010/2", src, active_bank);
      end
   endtask

   task automatic test_reset_mid_copy();
      int n, sr_n, en_n;
      logic [2:0] src;
      logic [36:0] all_out;
      ref_force = 1'b1;
      wait_start(5, n);
      ref_force = 1'b0;
      tick(60);
      #2 rst = 1'b1;
      #1;
      all_out = {u_we_bank, u_re_bank, ref_en_bank, start_sr_bank, active_bank, rd_sel,
                 ref_busy, ref_err, ref_cnt};
      checks++;
      if (all_out !== 37'd0) begin errors++; $display("FAIL midcopy_reset got %0h expected 0", all_out); end
      @(negedge clk);
      rst = 1'b0;
      ref_force = 1'b1;
      wait_start(5, n);
      ref_force = 1'b0;
      checks++;
      if (n !== 1 || start_sr_bank !== 3'b001) begin
         errors++; $display("FAIL restart_bank0 got n=%0d sr=%b expected 1/001", n, start_sr_bank);
      end
      run_copy(sr_n, en_n, src);
   endtask

   task automatic test_ref_err();
      int n, sr_n, en_n;
      logic [2:0] src;
      ref_done_i = 3'b000;
      ref_force  = 1'b1;
      wait_start(5, n);
      ref_force  = 1'b0;
      tick(20);
      checks++;
      if (ref_err !== 1'b0) begin errors++; $display("FAIL err_early got %b expected 0", ref_err); end
      run_copy(sr_n, en_n, src);
      checks++;
      if (ref_err !== 1'b1 || ref_cnt !== 16'd2) begin
         errors++; $display("FAIL err_set got err=%b cnt=%0d expected 1/2", ref_err, ref_cnt);
      end
      ref_done_i = 3'b111;
      ref_force  = 1'b1;
      wait_start(5, n);
      ref_force  = 1'b0;
      run_copy(sr_n, en_n, src);
      checks++;
      if (ref_err !== 1'b1 || ref_cnt !== 16'd3 || active_bank !== 2'd0) begin
         errors++;
         $display("FAIL err_sticky got err=%b cnt=%0d act=%0d expected 1/3/0", ref_err, ref_cnt, active_bank);
      end
      do_reset();
      checks++;
      if (ref_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b expected 0", ref_err); end
   endtask

   initial begin
      test_reset();
      test_timer_expiry();
      test_back_to_back();
      test_write_during_copy();
      test_en_hold();
      test_reset_mid_copy();
      test_ref_err();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
